// File: rtl/int_arbiter_pkg.sv
// Shared register offsets, FSM encodings and id bus width for the interrupt arbiter.
package int_arbiter_pkg;

    localparam int unsigned INTC_ID_BUS = 4;
    localparam int unsigned PRIO_W      = 2;

    localparam logic [7:0] INTC_PENDING  = 8'h00;
    localparam logic [7:0] INTC_ENABLE   = 8'h04;
    localparam logic [7:0] INTC_EDGE     = 8'h08;
    localparam logic [7:0] INTC_CLAIM    = 8'h0C;
    localparam logic [7:0] INTC_COMPLETE = 8'h10;
    localparam logic [7:0] INTC_STATUS   = 8'h14;
    localparam logic [7:0] INTC_PRIO     = 8'h18;

    typedef enum logic [1:0] {
        INTC_IDLE = 2'd0,
        INTC_REQ  = 2'd1,
        INTC_BUSY = 2'd2
    } intc_state_e;

endpackage

// File: rtl/int_prio_sel.sv
// Combinational winner select: highest priority then lowest index when INTC_PRIO_EN,
// otherwise fixed lowest-index-wins.
module int_prio_sel
    import int_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = INTC_ID_BUS
) (
    input  logic [NUM_SRC-1:0]        i_elig,
    input  logic [PRIO_W*NUM_SRC-1:0] i_prio,
    output logic                      o_valid_c,
    output logic [ID_W-1:0]           o_id_c
);

`ifdef INTC_PRIO_EN
    logic [PRIO_W-1:0] w_best;

    // Strict greater-than keeps the lowest index on a priority tie.
    always_comb begin
        o_valid_c = 1'b0;
        o_id_c    = '0;
        w_best    = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (i_elig[i] && (!o_valid_c || (i_prio[PRIO_W*i +: PRIO_W] > w_best))) begin
                o_valid_c = 1'b1;
                o_id_c    = ID_W'(i);
                w_best    = i_prio[PRIO_W*i +: PRIO_W];
            end
        end
    end
`else
    logic w_unused_prio;
    assign w_unused_prio = ^i_prio;

    always_comb begin
        o_valid_c = 1'b0;
        o_id_c    = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (i_elig[i] && !o_valid_c) begin
                o_valid_c = 1'b1;
                o_id_c    = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/int_arbiter.sv
// Memory-mapped interrupt controller with claim/complete handshake to the core.
// Optional priority arbitration enabled by defining INTC_PRIO_EN.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = INTC_ID_BUS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               wr_en_i,
    input  logic [31:0]        wr_addr_i,
    input  logic [31:0]        wr_data_i,
    input  logic [31:0]        rd_addr_i,
    output logic [31:0]        rd_data_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    localparam int unsigned PRIO_BITS = PRIO_W * NUM_SRC;

    logic [NUM_SRC-1:0]   r_src_q, r_src_qd, r_pend, r_enable, r_edge;
    logic [PRIO_BITS-1:0] w_prio;
    intc_state_e          r_state, w_state_nxt;
    logic                 r_irq, w_irq_nxt;
    logic [ID_W-1:0]      r_irq_id, w_irq_id_nxt, r_insvc, w_insvc_nxt;
    logic                 w_claim_ok, w_valid, w_id_ok, w_claim_wr, w_cmpl_wr;
    logic [ID_W-1:0]      w_win_id, w_wr_id;
    logic [7:0]           w_wr_off;
    logic [NUM_SRC-1:0]   w_rise, w_pending, w_elig, w_clr;
    logic                 w_unused_bits;

    assign w_wr_off   = wr_addr_i[7:0];
    assign w_wr_id    = wr_data_i[ID_W-1:0];
    assign w_id_ok    = (32'(w_wr_id) < NUM_SRC);
    assign w_claim_wr = wr_en_i && (w_wr_off == INTC_CLAIM) && w_id_ok;
    assign w_cmpl_wr  = wr_en_i && (w_wr_off == INTC_COMPLETE) && w_id_ok;

    // Fresh rising edges count as pending immediately so the request follows one cycle later.
    assign w_rise    = r_src_q & ~r_src_qd;
    assign w_pending = (r_edge & (r_pend | w_rise)) | (~r_edge & r_src_q);
    assign w_elig    = w_pending & r_enable;

    assign w_clr = (w_claim_ok ? (NUM_SRC'(1) << r_irq_id) : '0)
                 | ((wr_en_i && (w_wr_off == INTC_PENDING)) ? wr_data_i[NUM_SRC-1:0] : '0);

    assign w_unused_bits = ^{wr_addr_i[31:8], rd_addr_i[31:8], wr_data_i};

`ifdef INTC_PRIO_EN
    logic [PRIO_BITS-1:0] r_prio;
    assign w_prio = r_prio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= '0;
        end else if (wr_en_i && (w_wr_off == INTC_PRIO)) begin
            r_prio <= wr_data_i[PRIO_BITS-1:0];
        end
    end
`else
    assign w_prio = '0;
`endif

    int_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_sel (
        .i_elig    (w_elig),
        .i_prio    (w_prio),
        .o_valid_c (w_valid),
        .o_id_c    (w_win_id)
    );

    // Source sampling, pending and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_q  <= '0;
            r_src_qd <= '0;
            r_pend   <= '0;
            r_enable <= '0;
            r_edge   <= '0;
        end else begin
            r_src_q  <= src_i;
            r_src_qd <= r_src_q;
            r_pend   <= ((r_pend & ~w_clr) | w_rise) & r_edge;
            if (wr_en_i && (w_wr_off == INTC_ENABLE)) r_enable <= wr_data_i[NUM_SRC-1:0];
            if (wr_en_i && (w_wr_off == INTC_EDGE))   r_edge   <= wr_data_i[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= INTC_IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
            r_insvc  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_irq    <= w_irq_nxt;
            r_irq_id <= w_irq_id_nxt;
            r_insvc  <= w_insvc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_nxt    = 1'b0;
        w_irq_id_nxt = r_irq_id;
        w_insvc_nxt  = r_insvc;
        w_claim_ok   = 1'b0;
        case (r_state)
            INTC_IDLE: begin
                if (w_valid) begin
                    w_state_nxt  = INTC_REQ;
                    w_irq_nxt    = 1'b1;
                    w_irq_id_nxt = w_win_id;
                end
            end
            INTC_REQ: begin
                if (!w_valid) begin
                    w_state_nxt = INTC_IDLE;
                end else if (w_claim_wr && (w_wr_id == r_irq_id)) begin
                    w_state_nxt = INTC_BUSY;
                    w_insvc_nxt = w_wr_id;
                    w_claim_ok  = 1'b1;
                end else begin
                    w_irq_nxt    = 1'b1;
                    w_irq_id_nxt = w_win_id;
                end
            end
            INTC_BUSY: begin
                if (w_cmpl_wr && (w_wr_id == r_insvc)) w_state_nxt = INTC_IDLE;
            end
            default: w_state_nxt = INTC_IDLE;
        endcase
    end

    always_comb begin
        rd_data_o = '0;
        case (rd_addr_i[7:0])
            INTC_PENDING: rd_data_o = 32'(w_pending);
            INTC_ENABLE:  rd_data_o = 32'(r_enable);
            INTC_EDGE:    rd_data_o = 32'(r_edge);
            INTC_CLAIM: begin
                rd_data_o     = 32'(w_win_id);
                rd_data_o[31] = w_valid;
            end
            INTC_STATUS:  rd_data_o = (32'(r_insvc) << 8) | 32'(r_state);
`ifdef INTC_PRIO_EN
            INTC_PRIO:    rd_data_o = 32'(r_prio);
`endif
            default:      rd_data_o = '0;
        endcase
    end

    assign irq_o    = r_irq;
    assign irq_id_o = r_irq_id;

endmodule
